// File: rtl/hps_pixel_dispatcher.sv
// HPS mailbox pixel dispatcher: polls a shared SRAM command block, decodes point or
// row-fill entries and hands each pixel to a column unit over a one-hot request/ack.
module hps_pixel_dispatcher #(
    parameter int N_COLS      = 64,
    parameter int ADDR_W      = 8,
    parameter int ROW_W       = 10,
    parameter int COLOR_W     = 8,
    parameter int RD_LAT      = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    output logic [ADDR_W-1:0]   sram_address,
    output logic                sram_write,
    output logic [31:0]         sram_writedata,
    input  logic [31:0]         sram_readdata,
    output logic [N_COLS-1:0]   col_select,
    output logic [ROW_W-1:0]    row_select,
    output logic [COLOR_W-1:0]  pixel_color,
    input  logic [N_COLS-1:0]   return_sig,
    output logic                busy,
    output logic                frame_done,
    output logic [15:0]         drop_count
);

    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int RDC_W = $clog2(RD_LAT + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] MAX_COUNT = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(N_COLS - 1);
    localparam logic [RDC_W-1:0]  RD_DONE   = RDC_W'(RD_LAT);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [N_COLS-1:0] ONE_COL   = {{(N_COLS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_POLL, S_COUNT, S_FETCH, S_DRIVE, S_ACK, S_NEXT, S_CLEAR
    } state_t;

    state_t               state_q, state_d;
    logic [RDC_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic                 mode_q, mode_d;
    logic [ADDR_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 oor_q, oor_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 write_q, write_d;
    logic [N_COLS-1:0]    col_sel_q, col_sel_d;
    logic [ROW_W-1:0]     row_sel_q, row_sel_d;
    logic [COLOR_W-1:0]   pix_q, pix_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [15:0]          drop_q, drop_d;

    logic                 rd_done_s;
    logic                 ack_s;
    logic                 timeout_s;
    logic                 last_entry_s;
    logic                 x_oor_s;
    logic [ADDR_W-1:0]    cnt_clamp_s;
    logic                 unused_rdata_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'h0001;
        end
    endfunction

    assign rd_done_s      = (rd_cnt_q == RD_DONE);
    assign ack_s          = return_sig[col_q];
    assign timeout_s      = (to_cnt_q == TO_LAST);
    assign last_entry_s   = ((idx_q + ADDR_W'(1)) == count_q);
    assign x_oor_s        = ({22'h000000, sram_readdata[29:20]} >= 32'(N_COLS));
    assign cnt_clamp_s    = (sram_readdata[ADDR_W-1:0] > MAX_COUNT) ? MAX_COUNT
                                                                    : sram_readdata[ADDR_W-1:0];
    assign unused_rdata_s = ^{sram_readdata[31:30], sram_readdata[19:18]};

    // State and output registers; reset leaves the mailbox untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_POLL;
            rd_cnt_q  <= '0;
            mode_q    <= 1'b0;
            count_q   <= '0;
            idx_q     <= '0;
            col_q     <= '0;
            oor_q     <= 1'b0;
            row_q     <= '0;
            color_q   <= '0;
            to_cnt_q  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            col_sel_q <= '0;
            row_sel_q <= '0;
            pix_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            col_q     <= col_d;
            oor_q     <= oor_d;
            row_q     <= row_d;
            color_q   <= color_d;
            to_cnt_q  <= to_cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            col_sel_q <= col_sel_d;
            row_sel_q <= row_sel_d;
            pix_q     <= pix_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_POLL: begin
                if (rd_done_s && sram_readdata[0]) state_d = S_COUNT;
                else                               state_d = S_POLL;
            end
            S_COUNT: begin
                if (!rd_done_s)                state_d = S_COUNT;
                else if (cnt_clamp_s == '0)    state_d = S_CLEAR;
                else                           state_d = S_FETCH;
            end
            S_FETCH: begin
                if (rd_done_s) state_d = S_DRIVE;
                else           state_d = S_FETCH;
            end
            S_DRIVE: begin
                if (oor_q) state_d = S_NEXT;
                else       state_d = S_ACK;
            end
            S_ACK: begin
                if (!(ack_s || timeout_s))              state_d = S_ACK;
                else if (mode_q && (col_q != LAST_COL)) state_d = S_DRIVE;
                else                                    state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_entry_s) state_d = S_CLEAR;
                else              state_d = S_FETCH;
            end
            S_CLEAR: state_d = S_POLL;
            default: state_d = S_POLL;
        endcase
    end

    // Datapath and registered-output next values; each read restarts the latency counter.
    always_comb begin
        rd_cnt_d  = '0;
        mode_d    = mode_q;
        count_d   = count_q;
        idx_d     = idx_q;
        col_d     = col_q;
        oor_d     = oor_q;
        row_d     = row_q;
        color_d   = color_q;
        to_cnt_d  = to_cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        col_sel_d = col_sel_q;
        row_sel_d = row_sel_q;
        pix_d     = pix_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        drop_d    = drop_q;
        case (state_q)
            S_POLL: begin
                if (!rd_done_s) begin
                    rd_cnt_d = rd_cnt_q + RDC_W'(1);
                end else if (sram_readdata[0]) begin
                    mode_d = sram_readdata[1];
                    busy_d = 1'b1;
                    addr_d = ADDR_W'(1);
                end else begin
                    addr_d = '0;
                end
            end
            S_COUNT: begin
                if (!rd_done_s) begin
                    rd_cnt_d = rd_cnt_q + RDC_W'(1);
                end else begin
                    count_d = cnt_clamp_s;
                    idx_d   = '0;
                    if (cnt_clamp_s == '0) begin
                        addr_d  = '0;
                        write_d = 1'b1;
                    end else begin
                        addr_d = ADDR_W'(2);
                    end
                end
            end
            S_FETCH: begin
                if (!rd_done_s) begin
                    rd_cnt_d = rd_cnt_q + RDC_W'(1);
                end else begin
                    row_d   = sram_readdata[8 +: ROW_W];
                    color_d = sram_readdata[COLOR_W-1:0];
                    col_d   = mode_q ? '0 : sram_readdata[20 +: COL_W];
                    oor_d   = !mode_q && x_oor_s;
                end
            end
            S_DRIVE: begin
                if (oor_q) begin
                    drop_d = sat_inc(drop_q);
                end else begin
                    col_sel_d = ONE_COL << col_q;
                    row_sel_d = row_q;
                    pix_d     = color_q;
                    to_cnt_d  = '0;
                end
            end
            S_ACK: begin
                if (ack_s || timeout_s) begin
                    col_sel_d = '0;
                    to_cnt_d  = '0;
                    if (ack_s) drop_d = drop_q;
                    else       drop_d = sat_inc(drop_q);
                    if (mode_q && (col_q != LAST_COL)) col_d = col_q + COL_W'(1);
                    else                               col_d = col_q;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_NEXT: begin
                if (last_entry_s) begin
                    addr_d  = '0;
                    write_d = 1'b1;
                end else begin
                    idx_d  = idx_q + ADDR_W'(1);
                    addr_d = idx_q + ADDR_W'(3);
                end
            end
            S_CLEAR: begin
                addr_d  = '0;
                write_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign sram_address   = addr_q;
    assign sram_write     = write_q;
    assign sram_writedata = 32'h0000_0000;
    assign col_select     = col_sel_q;
    assign row_select     = row_sel_q;
    assign pixel_color    = pix_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_hps_pixel_dispatcher.sv
// Directed bench for hps_pixel_dispatcher: mailbox SRAM model, per-column ack responder,
// event monitor, and table-driven frame checks plus multi-cycle corner sequences.
module tb_hps_pixel_dispatcher;

    localparam int N_COLS = 64, ADDR_W = 8, ROW_W = 10, COLOR_W = 8, RD_LAT = 2, ACK_TIMEOUT = 255;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [ADDR_W-1:0]   sram_address;
    logic                sram_write;
    logic [31:0]         sram_writedata;
    logic [31:0]         sram_readdata;
    logic [N_COLS-1:0]   col_select;
    logic [ROW_W-1:0]    row_select;
    logic [COLOR_W-1:0]  pixel_color;
    logic [N_COLS-1:0]   return_sig;
    logic                busy;
    logic                frame_done;
    logic [15:0]         drop_count;

    always #5 clock = ~clock;

    hps_pixel_dispatcher #(
        .N_COLS(N_COLS), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COLOR_W(COLOR_W),
        .RD_LAT(RD_LAT), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .sram_address(sram_address), .sram_write(sram_write),
        .sram_writedata(sram_writedata), .sram_readdata(sram_readdata),
        .col_select(col_select), .row_select(row_select), .pixel_color(pixel_color),
        .return_sig(return_sig), .busy(busy), .frame_done(frame_done),
        .drop_count(drop_count)
    );

    // Mailbox SRAM: data appears RD_LAT cycles after the address.
    logic [31:0] mem  [0:255];
    logic [31:0] pipe [0:RD_LAT-1];
    logic        mem_clr = 1'b1;
    logic        ld_en   = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [31:0] ld_data = 32'h0;

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (sram_write) begin
            mem[sram_address] <= sram_writedata;
        end
        pipe[0] <= mem[sram_address];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sram_readdata = pipe[RD_LAT-1];

    // Column responder: column c acks in its ack_delay[c]-th held cycle (0 = never).
    int                ack_delay [N_COLS];
    logic [N_COLS-1:0] noise = '0;
    int                hold_cnt = 0;

    always @(posedge clock) hold_cnt <= (col_select != '0) ? hold_cnt + 1 : 0;

    always_comb begin
        return_sig = '0;
        for (int c = 0; c < N_COLS; c++)
            return_sig[c] = (col_select[c] && ack_delay[c] != 0 && (hold_cnt + 1) >= ack_delay[c])
                          || (noise[c] && !col_select[c]);
    end

    // Monitor of requests, mailbox writes and frame pulses.
    int cyc = 0, frame_cnt = 0, wr_cnt = 0, wr_bad = 0, onehot_bad = 0, hcur = 0;
    int busy_rise = 0, wr_cyc = 0;
    int ev_col[$], ev_row[$], ev_color[$], ev_hold[$], ev_cyc[$];
    logic [N_COLS-1:0] prev_sel = '0;
    logic prev_busy = 1'b0;

    function automatic int sel_index(input logic [N_COLS-1:0] s);
        for (int i = 0; i < N_COLS; i++) if (s[i]) return i;
        return -1;
    endfunction

    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (col_select != '0) begin
            if (!$onehot(col_select)) onehot_bad <= onehot_bad + 1;
            if (prev_sel == '0) begin
                ev_col.push_back(sel_index(col_select));
                ev_row.push_back(int'(row_select));
                ev_color.push_back(int'(pixel_color));
                ev_cyc.push_back(cyc);
                hcur <= 1;
            end else begin
                hcur <= hcur + 1;
            end
        end else if (prev_sel != '0) begin
            ev_hold.push_back(hcur);
            hcur <= 0;
        end
        prev_sel <= col_select;
        if (sram_write) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
            if (sram_address != '0 || sram_writedata != 32'h0) wr_bad <= wr_bad + 1;
        end
        if (frame_done) frame_cnt <= frame_cnt + 1;
        if (busy && !prev_busy) busy_rise <= cyc;
        prev_busy <= busy;
    end

    typedef struct {
        int x; int y; int color;
        int exp_col; int exp_row; int exp_color; int exp_gap;
    } vec_t;
    vec_t vecs [6];

    int n_cmp = 0, n_fail = 0, exp_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic ld(input int a, input logic [31:0] d);
        @(negedge clock);
        ld_en   = 1'b1;
        ld_addr = a[7:0];
        ld_data = d;
        @(negedge clock);
        ld_en   = 1'b0;
    endtask

    function automatic logic [31:0] mk(input int x, input int y, input int c);
        return {2'b00, x[9:0], 2'b00, y[9:0], c[7:0]};
    endfunction

    task automatic wait_frame(input int target, input int budget, input string name);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (frame_cnt < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no frame_done within %0d cycles", name, budget);
        end
    endtask

    task automatic run_points(input int first, input int n, input int drops);
        int b_ev, b_hold, b_fr, b_wr, b_bad, k, ne;
        b_ev = ev_col.size(); b_hold = ev_hold.size();
        b_fr = frame_cnt; b_wr = wr_cnt; b_bad = wr_bad;
        ld(1, n);
        for (int i = 0; i < n; i++)
            ld(2 + i, mk(vecs[first+i].x, vecs[first+i].y, vecs[first+i].color));
        ld(0, 32'h1);
        wait_frame(b_fr + 1, 2000, "pt_frame_timeout");
        repeat (4) tick();
        ne = 0;
        for (int i = 0; i < n; i++) if (vecs[first+i].exp_col >= 0) ne++;
        chk("pt_event_count", ev_col.size() - b_ev, ne);
        k = 0;
        for (int i = 0; i < n; i++) begin
            if (vecs[first+i].exp_col >= 0) begin
                if (b_ev + k < ev_col.size() && b_hold + k < ev_hold.size()) begin
                    chk("pt_col", ev_col[b_ev+k], vecs[first+i].exp_col);
                    chk("pt_row", ev_row[b_ev+k], vecs[first+i].exp_row);
                    chk("pt_color", ev_color[b_ev+k], vecs[first+i].exp_color);
                    chk("pt_hold", ev_hold[b_hold+k], 1);
                    if (k > 0) chk("pt_gap", ev_cyc[b_ev+k] - ev_cyc[b_ev+k-1], vecs[first+i].exp_gap);
                end
                k++;
            end
        end
        exp_drop += drops;
        chk("pt_drop_count", int'(drop_count), exp_drop);
        chk("pt_frame_pulses", frame_cnt - b_fr, 1);
        chk("pt_clear_writes", wr_cnt - b_wr, 1);
        chk("pt_bad_writes", wr_bad - b_bad, 0);
        chk("pt_mailbox_cleared", int'(mem[0]), 0);
        chk("pt_busy_low", int'(busy), 0);
    endtask

    initial begin
        int b_ev, b_hold, b_fr, b_wr, n;
        vecs[0] = '{x: 0,  y: 5,    color: 8'hFF, exp_col: 0,  exp_row: 5,    exp_color: 8'hFF, exp_gap: 0};
        vecs[1] = '{x: 63, y: 479,  color: 8'h1C, exp_col: 63, exp_row: 479,  exp_color: 8'h1C, exp_gap: 6};
        vecs[2] = '{x: 10, y: 0,    color: 8'h00, exp_col: 10, exp_row: 0,    exp_color: 8'h00, exp_gap: 6};
        vecs[3] = '{x: 7,  y: 100,  color: 8'h55, exp_col: 7,  exp_row: 100,  exp_color: 8'h55, exp_gap: 0};
        vecs[4] = '{x: 64, y: 9,    color: 8'h33, exp_col: -1, exp_row: 0,    exp_color: 0,     exp_gap: 0};
        vecs[5] = '{x: 62, y: 1023, color: 8'hAA, exp_col: 62, exp_row: 1023, exp_color: 8'hAA, exp_gap: 11};
        for (int c = 0; c < N_COLS; c++) ack_delay[c] = 1;

        // Reset values while reset is held.
        repeat (4) tick();
        chk("rst_sram_address", int'(sram_address), 0);
        chk("rst_sram_write", int'(sram_write), 0);
        chk("rst_sram_writedata", int'(sram_writedata), 0);
        chk("rst_col_select", int'(col_select != '0), 0);
        chk("rst_row_select", int'(row_select), 0);
        chk("rst_pixel_color", int'(pixel_color), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_drop_count", int'(drop_count), 0);
        mem_clr = 1'b0;
        reset   = 1'b0;
        repeat (3) tick();

        run_points(0, 3, 0);
        run_points(3, 3, 1);

        // Row fill: one entry drives every column in order.
        b_ev = ev_col.size(); b_fr = frame_cnt; b_wr = wr_cnt;
        ld(1, 1); ld(2, mk(5, 7, 8'hE0)); ld(0, 32'h3);
        wait_frame(b_fr + 1, 2000, "fill_frame_timeout");
        repeat (4) tick();
        chk("fill_event_count", ev_col.size() - b_ev, N_COLS);
        for (int i = 0; i < N_COLS; i++) begin
            if (b_ev + i < ev_col.size()) begin
                chk("fill_col", ev_col[b_ev+i], i);
                chk("fill_row", ev_row[b_ev+i], 7);
                chk("fill_color", ev_color[b_ev+i], 8'hE0);
            end
        end
        chk("fill_clear_writes", wr_cnt - b_wr, 1);
        chk("fill_drop_count", int'(drop_count), exp_drop);
        chk("fill_onehot_violations", onehot_bad, 0);

        // Delayed ack on column 4, none on column 5; other columns' acks are noise.
        ack_delay[4] = 20; ack_delay[5] = 0; noise = '1;
        b_ev = ev_col.size(); b_hold = ev_hold.size(); b_fr = frame_cnt;
        ld(1, 2); ld(2, mk(4, 20, 8'h44)); ld(3, mk(5, 21, 8'h55)); ld(0, 32'h1);
        wait_frame(b_fr + 1, 1000, "slow_frame_timeout");
        repeat (4) tick();
        noise = '0; ack_delay[4] = 1; ack_delay[5] = 1;
        exp_drop += 1;
        chk("slow_event_count", ev_col.size() - b_ev, 2);
        if (b_ev + 1 < ev_col.size() && b_hold + 1 < ev_hold.size()) begin
            chk("slow_col_a", ev_col[b_ev], 4);
            chk("slow_hold_a", ev_hold[b_hold], 20);
            chk("slow_col_b", ev_col[b_ev+1], 5);
            chk("slow_hold_b", ev_hold[b_hold+1], ACK_TIMEOUT);
        end
        chk("slow_drop_count", int'(drop_count), exp_drop);
        chk("slow_mailbox_cleared", int'(mem[0]), 0);

        // count=0: straight to the clear write, no requests.
        b_ev = ev_col.size(); b_fr = frame_cnt; b_wr = wr_cnt;
        ld(1, 0); ld(0, 32'h1);
        wait_frame(b_fr + 1, 100, "cnt0_frame_timeout");
        repeat (4) tick();
        chk("cnt0_event_count", ev_col.size() - b_ev, 0);
        chk("cnt0_clear_writes", wr_cnt - b_wr, 1);
        chk("cnt0_clear_within_bound", int'((wr_cyc > busy_rise) && (wr_cyc - busy_rise) <= 2 * RD_LAT + 3), 1);
        chk("cnt0_frame_pulses", frame_cnt - b_fr, 1);

        // Count above the limit is clamped to 254 entries, all out of range.
        b_ev = ev_col.size(); b_fr = frame_cnt;
        for (int i = 0; i < 254; i++) ld(2 + i, mk(64, 0, 0));
        ld(1, 255); ld(0, 32'h1);
        wait_frame(b_fr + 1, 3000, "clamp_frame_timeout");
        repeat (4) tick();
        exp_drop += 254;
        chk("clamp_drop_count", int'(drop_count), exp_drop);
        chk("clamp_event_count", ev_col.size() - b_ev, 0);
        chk("clamp_mailbox_cleared", int'(mem[0]), 0);

        // Reset in the middle of an ack wait.
        ack_delay[9] = 0;
        ld(1, 1); ld(2, mk(9, 3, 8'h99)); ld(0, 32'h1);
        n = 0;
        while (!col_select[9] && n < 200) begin
            tick();
            n++;
        end
        chk("rst_mid_request_seen", int'(col_select[9]), 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("rstmid_col_select", int'(col_select != '0), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_sram_write", int'(sram_write), 0);
        chk("rstmid_sram_address", int'(sram_address), 0);
        chk("rstmid_row_select", int'(row_select), 0);
        chk("rstmid_pixel_color", int'(pixel_color), 0);
        chk("rstmid_drop_count", int'(drop_count), 0);
        chk("rstmid_mailbox_kept", int'(mem[0]), 1);
        reset = 1'b0;
        ack_delay[9] = 1;
        exp_drop = 0;
        b_ev = ev_col.size(); b_fr = frame_cnt;
        wait_frame(b_fr + 1, 200, "rstmid_frame_timeout");
        repeat (4) tick();
        chk("rstmid_event_count", ev_col.size() - b_ev, 1);
        if (b_ev < ev_col.size()) chk("rstmid_col", ev_col[b_ev], 9);
        chk("rstmid_drop_after", int'(drop_count), exp_drop);
        chk("rstmid_mailbox_cleared", int'(mem[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
